// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// ifetch_ctrl : PC-driven instruction fetch, req/ack memory side, valid/ready decode side
// Revision    : 1.0
// ============================================================================
module ifetch_ctrl #(
  parameter logic [31:0] IM_BASE       = 32'h0000_3000,
  parameter int unsigned IM_SIZE_WORDS = 1024,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Redirect,
  output logic        PCEn,
  output logic        ImReq,
  output logic [31:0] ImAddr,
  input  logic        ImAck,
  input  logic [31:0] ImRdata,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        DecReady,
  output logic        AddrErr,
  output logic        Timeout
);

  localparam int unsigned    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [32:0]    IM_LO    = {1'b0, IM_BASE};
  localparam logic [32:0]    IM_HI    = {1'b0, IM_BASE} + (33'(IM_SIZE_WORDS) << 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t         state_q;
  logic           imreq_q;
  logic [31:0]    imaddr_q;
  logic           valid_q;
  logic [31:0]    instr_q;
  logic [31:0]    instrpc_q;
  logic           pcen_q;
  logic           addrerr_q;
  logic           timeout_q;
  logic [CW-1:0]  cnt_q;

  logic [31:0]    next_addr;
  logic           pc_legal;
  logic           next_legal;
  logic           transfer;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} >= IM_LO) && ({1'b0, a} < IM_HI);
  endfunction

  // The PC register only loads nPC at the end of the PCEn cycle, so a transfer
  // in that cycle fetches the sequential successor of the delivered word.
  assign next_addr  = pcen_q ? (instrpc_q + 32'd4) : PC;
  assign pc_legal   = addr_legal(PC);
  assign next_legal = addr_legal(next_addr);
  assign transfer   = valid_q & DecReady;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      imreq_q   <= 1'b0;
      imaddr_q  <= IM_BASE;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      instrpc_q <= '0;
      pcen_q    <= 1'b0;
      addrerr_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pcen_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!Redirect) begin
            if (!pc_legal) begin
              addrerr_q <= 1'b1;
            end else begin
              imreq_q  <= 1'b1;
              imaddr_q <= PC;
              cnt_q    <= '0;
              state_q  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (ImAck) begin
            imreq_q <= 1'b0;
            if (Redirect) begin
              state_q <= S_IDLE;
            end else begin
              instr_q   <= ImRdata;
              instrpc_q <= imaddr_q;
              valid_q   <= 1'b1;
              pcen_q    <= 1'b1;
              state_q   <= S_HOLD;
            end
          end else if (Redirect) begin
            state_q <= S_DROP;
          end else begin
            if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) timeout_q <= 1'b1;
          end
        end
        // A request is never withdrawn; wait out the stale ack and discard it.
        S_DROP: begin
          if (ImAck) begin
            imreq_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (Redirect) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (transfer) begin
            valid_q <= 1'b0;
            if (next_legal) begin
              imreq_q  <= 1'b1;
              imaddr_q <= next_addr;
              cnt_q    <= '0;
              state_q  <= S_REQ;
            end else begin
              addrerr_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PCEn       = pcen_q;
  assign ImReq      = imreq_q;
  assign ImAddr     = imaddr_q;
  assign InstrValid = valid_q;
  assign Instr      = instr_q;
  assign InstrPC    = instrpc_q;
  assign AddrErr    = addrerr_q;
  assign Timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ifetch_ctrl : directed self-checking bench for ifetch_ctrl
// Revision       : 1.0
// ============================================================================
module tb_ifetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic        Redirect;
  logic        PCEn;
  logic        ImReq;
  logic [31:0] ImAddr;
  logic        ImAck;
  logic [31:0] ImRdata;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        DecReady;
  logic        AddrErr;
  logic        Timeout;

  int checks   = 0;
  int errors   = 0;
  int pcen_cnt = 0;

  ifetch_ctrl #(
    .IM_BASE       (32'h0000_3000),
    .IM_SIZE_WORDS (1024),
    .TIMEOUT       (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PC         (PC),
    .Redirect   (Redirect),
    .PCEn       (PCEn),
    .ImReq      (ImReq),
    .ImAddr     (ImAddr),
    .ImAck      (ImAck),
    .ImRdata    (ImRdata),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .DecReady   (DecReady),
    .AddrErr    (AddrErr),
    .Timeout    (Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the modelled PC register advances by 4 when PCEn was high.
  task automatic tick();
    logic p;
    p = PCEn;
    @(posedge Clk);
    #1;
    if (p === 1'b1) begin
      PC = PC + 32'd4;
      pcen_cnt++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imreq"},  {31'd0, ImReq},      32'd0);
    chk({tag, "_imaddr"}, ImAddr,              32'h0000_3000);
    chk({tag, "_valid"},  {31'd0, InstrValid}, 32'd0);
    chk({tag, "_instr"},  Instr,               32'd0);
    chk({tag, "_ipc"},    InstrPC,             32'd0);
    chk({tag, "_pcen"},   {31'd0, PCEn},       32'd0);
    chk({tag, "_aerr"},   {31'd0, AddrErr},    32'd0);
    chk({tag, "_tout"},   {31'd0, Timeout},    32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    PC       = 32'h0000_3000;
    Redirect = 1'b0;
    ImAck    = 1'b0;
    ImRdata  = 32'd0;
    DecReady = 1'b1;
    @(posedge Clk);
    #1;
    tick();
    chk_reset("rst");

    // Basic fetch, ack two cycles after ImReq, decode ready
    Reset = 1'b0;
    tick();
    chk("f1_req",  {31'd0, ImReq}, 32'd1);
    chk("f1_addr", ImAddr, 32'h0000_3000);
    tick();
    chk("f1_novalid", {31'd0, InstrValid}, 32'd0);
    ImAck = 1'b1; ImRdata = 32'hDEAD_0001;
    tick();
    ImAck = 1'b0;
    chk("f1_valid", {31'd0, InstrValid}, 32'd1);
    chk("f1_instr", Instr, 32'hDEAD_0001);
    chk("f1_ipc",   InstrPC, 32'h0000_3000);
    chk("f1_pcen",  {31'd0, PCEn}, 32'd1);
    chk("f1_reqlo", {31'd0, ImReq}, 32'd0);
    tick();
    chk("f2_req",     {31'd0, ImReq}, 32'd1);
    chk("f2_addr",    ImAddr, 32'h0000_3004);
    chk("f2_validlo", {31'd0, InstrValid}, 32'd0);
    chk("f2_pcenlo",  {31'd0, PCEn}, 32'd0);
    chk("f1_pcencnt", pcen_cnt, 32'd1);

    // Decode stalls for 5 cycles in HOLD
    DecReady = 1'b0;
    ImAck = 1'b1; ImRdata = 32'hDEAD_0002;
    tick();
    ImAck = 1'b0;
    chk("st_valid", {31'd0, InstrValid}, 32'd1);
    chk("st_ipc",   InstrPC, 32'h0000_3004);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_hold_valid", {31'd0, InstrValid}, 32'd1);
      chk("st_hold_instr", Instr, 32'hDEAD_0002);
      chk("st_hold_noreq", {31'd0, ImReq}, 32'd0);
      chk("st_hold_nopcen", {31'd0, PCEn}, 32'd0);
    end
    DecReady = 1'b1;
    tick();
    chk("st_req",     {31'd0, ImReq}, 32'd1);
    chk("st_addr",    ImAddr, 32'h0000_3008);
    chk("st_pcencnt", pcen_cnt, 32'd2);

    // Redirect in REQ before ack: request held, data discarded
    Redirect = 1'b1;
    tick();
    Redirect = 1'b0; PC = 32'h0000_3100;
    chk("rd_req_held", {31'd0, ImReq}, 32'd1);
    chk("rd_addr_held", ImAddr, 32'h0000_3008);
    tick();
    chk("rd_req_held2", {31'd0, ImReq}, 32'd1);
    ImAck = 1'b1; ImRdata = 32'h0BAD_0BAD;
    tick();
    ImAck = 1'b0;
    chk("rd_reqlo",   {31'd0, ImReq}, 32'd0);
    chk("rd_novalid", {31'd0, InstrValid}, 32'd0);
    chk("rd_nopcen",  {31'd0, PCEn}, 32'd0);
    tick();
    chk("rd_newreq",  {31'd0, ImReq}, 32'd1);
    chk("rd_newaddr", ImAddr, 32'h0000_3100);
    chk("rd_pcencnt", pcen_cnt, 32'd2);

    // Redirect coincident with ack
    Redirect = 1'b1; ImAck = 1'b1; ImRdata = 32'h0BAD_0001;
    tick();
    Redirect = 1'b0; ImAck = 1'b0; PC = 32'h0000_3200;
    chk("ra_reqlo",   {31'd0, ImReq}, 32'd0);
    chk("ra_novalid", {31'd0, InstrValid}, 32'd0);
    chk("ra_nopcen",  {31'd0, PCEn}, 32'd0);
    tick();
    chk("ra_req",  {31'd0, ImReq}, 32'd1);
    chk("ra_addr", ImAddr, 32'h0000_3200);
    ImAck = 1'b1; ImRdata = 32'h0000_1234;
    tick();
    ImAck = 1'b0;
    chk("ra_valid", {31'd0, InstrValid}, 32'd1);
    chk("ra_instr", Instr, 32'h0000_1234);
    chk("ra_ipc",   InstrPC, 32'h0000_3200);
    tick();
    chk("to_req0",  {31'd0, ImReq}, 32'd1);
    chk("to_addr0", ImAddr, 32'h0000_3204);

    // Ack withheld 20 cycles; Timeout after the 16th REQ cycle
    for (int j = 1; j <= 20; j++) begin
      tick();
      chk("to_timeout", {31'd0, Timeout}, (j >= 16) ? 32'd1 : 32'd0);
    end
    chk("to_req_still", {31'd0, ImReq}, 32'd1);
    ImAck = 1'b1; ImRdata = 32'h5555_AAAA;
    tick();
    ImAck = 1'b0;
    chk("to_valid",  {31'd0, InstrValid}, 32'd1);
    chk("to_instr",  Instr, 32'h5555_AAAA);
    chk("to_ipc",    InstrPC, 32'h0000_3204);
    chk("to_sticky", {31'd0, Timeout}, 32'd1);
    tick();
    chk("to_next_addr", ImAddr, 32'h0000_3208);
    chk("to_pcencnt", pcen_cnt, 32'd4);

    // Reset asserted mid-REQ
    Reset = 1'b1;
    tick();
    chk_reset("midrst");

    // Misaligned PC
    PC = 32'h0000_3002;
    Reset = 1'b0;
    tick();
    chk("ae1_aerr",  {31'd0, AddrErr}, 32'd1);
    chk("ae1_noreq", {31'd0, ImReq}, 32'd0);
    tick();
    chk("ae1_sticky", {31'd0, AddrErr}, 32'd1);
    chk("ae1_noreq2", {31'd0, ImReq}, 32'd0);
    Reset = 1'b1;
    tick();
    chk("ae1_clear", {31'd0, AddrErr}, 32'd0);

    // One past the last word
    PC = 32'h0000_4000;
    Reset = 1'b0;
    tick();
    chk("ae2_aerr",  {31'd0, AddrErr}, 32'd1);
    chk("ae2_noreq", {31'd0, ImReq}, 32'd0);

    // Last legal word
    Reset = 1'b1;
    tick();
    PC = 32'h0000_3FFC;
    Reset = 1'b0;
    tick();
    chk("lw_req",  {31'd0, ImReq}, 32'd1);
    chk("lw_addr", ImAddr, 32'h0000_3FFC);
    chk("lw_aerr", {31'd0, AddrErr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Fetch controller between the PC register and decode.
- Takes the current PC and runs a req/ack read of a multi-cycle instruction memory.
- Presents the fetched word to decode through a valid/ready handshake.
- Pulses PCEn so the PC register advances only on a completed fetch; handles branch/jump redirect, address errors and fetch timeout.

Parameters:
- IM_BASE, 32'h0000_3000, first legal instruction byte address (also the PC reset value).
- IM_SIZE_WORDS, 1024, number of 32-bit words in instruction memory.
- TIMEOUT, 16, cycles in REQ without ImAck before Timeout is raised (≥2).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- PC  in  32  current PC-register value.
- Redirect  in  1  one-cycle pulse; PC holds the redirect target from the next cycle.
- PCEn  out  1  one-cycle pulse; PC register loads nPC on this edge.
- ImReq  out  1  instruction memory read request.
- ImAddr  out  32  read byte address; stable while ImReq=1.
- ImAck  in  1  memory read done; ImRdata valid this cycle.
- ImRdata  in  32  instruction word.
- InstrValid  out  1  Instr/InstrPC valid for decode.
- Instr  out  32  fetched instruction.
- InstrPC  out  32  address of Instr.
- DecReady  in  1  decode accepts this cycle.
- AddrErr  out  1  sticky: illegal PC seen.
- Timeout  out  1  sticky: REQ exceeded TIMEOUT cycles.

Behaviour:
- Reset (synchronous, active-high, Clk) dominates all inputs, including mid-handshake. Reset values:
  - state=IDLE; ImReq=0, ImAddr=IM_BASE.
  - InstrValid=0, Instr=0, InstrPC=0.
  - PCEn=0, AddrErr=0, Timeout=0, wait counter=0.
  - Memory must tolerate ImReq dropping before ack.
- All outputs are registered.
- Legal PC: PC[1:0]==0 and IM_BASE ≤ PC < IM_BASE+4*IM_SIZE_WORDS. Compare in 33-bit arithmetic (no wrap).
- IDLE:
  - Redirect=1: stay IDLE (current PC is stale).
  - Else PC illegal: AddrErr<=1, stay IDLE.
  - Else ImReq<=1, ImAddr<=PC, counter<=0, go REQ.
- REQ: ImReq=1, ImAddr held.
  - ImAck=1 and Redirect=0: Instr<=ImRdata, InstrPC<=ImAddr, InstrValid<=1, ImReq<=0, PCEn<=1 for exactly one cycle, go HOLD. Fetch latency is ack cycle +1.
  - ImAck=1 and Redirect=1: discard data, no PCEn, ImReq<=0, go IDLE.
  - ImAck=0 and Redirect=1: go DROP.
  - ImAck=0 and Redirect=0: counter++ (saturating). When counter reaches TIMEOUT-1, Timeout<=1 (sticky); keep waiting.
- DROP: ImReq stays 1, since a request is never withdrawn except by Reset. On ImAck: discard, ImReq<=0, go IDLE. Redirects in DROP are absorbed.
- HOLD: InstrValid=1; Instr and InstrPC stable until transfer. Transfer = InstrValid & DecReady.
  - Redirect=1 (with or without transfer): InstrValid<=0, go IDLE. A same-cycle transfer still counts as delivered.
  - Transfer only: InstrValid<=0. If PC is legal: ImReq<=1, ImAddr<=PC, go REQ (no bubble cycle). Else AddrErr<=1, go IDLE.
  - No transfer: hold.
- At most one fetch outstanding; at most one PCEn per delivered instruction; PCEn never asserted for a discarded fetch.
- AddrErr and Timeout clear only on Reset.

Test Plan:
- Reset, then ImAck 2 cycles after ImReq, DecReady=1:
  - ImAddr=0x3000; InstrValid rises the cycle after ack with Instr=ImRdata, InstrPC=0x3000.
  - PCEn pulses exactly once.
  - Next ImAddr=0x3004 on the cycle after transfer.
- DecReady=0 for 5 cycles in HOLD: Instr and InstrValid stable, no new ImReq, no extra PCEn. Raising DecReady gives transfer, then REQ the next cycle.
- Redirect while in REQ before ack (PC becomes 0x3100):
  - ImReq held until ack, data discarded, InstrValid stays 0, no PCEn.
  - Then IDLE, next ImAddr=0x3100.
- Redirect and ImAck in the same cycle: no InstrValid, no PCEn. Next fetch from the target after one IDLE cycle.
- PC=0x3002 and PC=0x4000 (IM_SIZE_WORDS=1024): AddrErr=1 sticky, no ImReq. Reset clears it.
- ImAck withheld 20 cycles (TIMEOUT=16): Timeout=1 after the 16th REQ cycle, ImReq still 1. Later ack completes normally. Reset asserted mid-REQ drops ImReq next cycle, all outputs at reset values.
